mesh_feeder: RTL and testbench

MESH_FEEDER -- requirements
Module: mesh_feeder

---
 rtl/mesh_feeder_pkg.sv | 24 ++
 rtl/mesh_feeder_matrix_store.sv | 47 ++++
 rtl/mesh_feeder.sv | 192 +++++++++++++++++++
 tb/tb_mesh_feeder.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_feeder_pkg.sv
// Shared definitions for the mesh operand feeder.
//   MESH_N / MESH_DATA_WIDTH : default mesh dimension and operand width
//   feeder_state_t          : sequencing FSM states
//   addr_width()            : element address width for an N-wide mesh
package mesh_feeder_pkg;

   localparam int MESH_N          = 3;
   localparam int MESH_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_WAIT_DIAG,
      ST_GAP,
      ST_DONE
   } feeder_state_t;

   // A 1x1 mesh still needs a one-bit address port.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mesh_feeder_matrix_store.sv
// N x N operand register file with one write port and one vector read port.
//   clk, rst_n        : clock, asynchronous active-low reset (clears all elements)
//   wr_en             : write wr_data to element [wr_row][wr_col]
//   wr_row, wr_col    : element address; indices >= N are dropped
//   rd_idx            : row (READ_COLUMN=0) or column (READ_COLUMN=1) to read
//   rd_data[0:N-1]    : combinational read of that row or column
module feeder_matrix_store
   import mesh_feeder_pkg::*;
#(
   parameter int N           = MESH_N,
   parameter int DATA_WIDTH  = MESH_DATA_WIDTH,
   parameter bit READ_COLUMN = 1'b0,
   parameter int AW          = addr_width(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_row,
   input  logic [AW-1:0]         wr_col,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]         rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data [N]
);

   logic [DATA_WIDTH-1:0] mem [N][N];

   // Out-of-range addresses are dropped so a non-power-of-two N cannot
   // alias a write onto a real element.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               mem[r][c] <= '0;
            end
         end
      end else if (wr_en && (int'(wr_row) < N) && (int'(wr_col) < N)) begin
         mem[wr_row][wr_col] <= wr_data;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         rd_data[i] = READ_COLUMN ? mem[i][rd_idx] : mem[rd_idx][i];
      end
   end

endmodule

// File: rtl/mesh_feeder.sv
// Feeds an N x N systolic mesh one outer-product step at a time: step k
// presents column k of A on west_o and row k of B on north_o, pulses
// inputs_valid_o, waits for every diagonal PE to report, idles GAP_CYCLES,
// and moves to the next step.
//   clk_i, rstn_i             : clock, asynchronous active-low reset
//   a_wr_en_i, b_wr_en_i      : element writes into A / B (accepted in IDLE only)
//   wr_row_i, wr_col_i        : element address
//   wr_data_i                 : element value (opaque bit pattern)
//   start_i                   : begin a sequence (accepted in IDLE only)
//   north_o[0:N-1]            : B[k][j] to the mesh north edge
//   west_o[0:N-1]             : A[i][k] to the mesh west edge
//   inputs_valid_o            : one-cycle operand strobe to the mesh
//   diag_valid_i[0:N-1]       : completion from mesh PE [i][i]
//   busy_o, done_o, error_o   : not idle / sequence-end pulse / sticky timeout
module mesh_feeder
   import mesh_feeder_pkg::*;
#(
   parameter int N              = MESH_N,
   parameter int DATA_WIDTH     = MESH_DATA_WIDTH,
   parameter int GAP_CYCLES     = 5,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      a_wr_en_i,
   input  logic                      b_wr_en_i,
   input  logic [addr_width(N)-1:0]  wr_row_i,
   input  logic [addr_width(N)-1:0]  wr_col_i,
   input  logic [DATA_WIDTH-1:0]     wr_data_i,
   input  logic                      start_i,
   output logic [DATA_WIDTH-1:0]     north_o [N],
   output logic [DATA_WIDTH-1:0]     west_o [N],
   output logic                      inputs_valid_o,
   input  logic                      diag_valid_i [N],
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o
);

   localparam int AW      = addr_width(N);
   localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW-1:0] K_LAST       = AW'(N - 1);

   feeder_state_t         state;
   logic [AW-1:0]         k;
   logic [CW-1:0]         cnt;
   logic [N-1:0]          flags;
   logic [N-1:0]          seen;
   logic [AW-1:0]         rd_idx;
   logic                  a_wr;
   logic                  b_wr;
   logic [DATA_WIDTH-1:0] a_col [N];
   logic [DATA_WIDTH-1:0] b_row [N];

   assign a_wr = a_wr_en_i && (state == ST_IDLE);
   assign b_wr = b_wr_en_i && (state == ST_IDLE);

   // Operands are loaded on entry to SETUP, so the stores are addressed with
   // the step about to start: 0 from IDLE, k+1 on the final GAP cycle.
   assign rd_idx = (state == ST_GAP && k != K_LAST) ? k + AW'(1) : '0;

   always_comb begin
      seen = flags;
      for (int i = 0; i < N; i++) begin
         seen[i] = flags[i] | diag_valid_i[i];
      end
   end

   feeder_matrix_store #(
      .N           (N),
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_COLUMN (1'b1),
      .AW          (AW)
   ) u_store_a (
      .clk     (clk_i),
      .rst_n   (rstn_i),
      .wr_en   (a_wr),
      .wr_row  (wr_row_i),
      .wr_col  (wr_col_i),
      .wr_data (wr_data_i),
      .rd_idx  (rd_idx),
      .rd_data (a_col)
   );

   feeder_matrix_store #(
      .N           (N),
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_COLUMN (1'b0),
      .AW          (AW)
   ) u_store_b (
      .clk     (clk_i),
      .rst_n   (rstn_i),
      .wr_en   (b_wr),
      .wr_row  (wr_row_i),
      .wr_col  (wr_col_i),
      .wr_data (wr_data_i),
      .rd_idx  (rd_idx),
      .rd_data (b_row)
   );

   // cnt is shared: WAIT_DIAG dwell and GAP length never overlap.
   // A diagonal arriving on the last allowed WAIT_DIAG cycle still wins
   // over the timeout.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state          <= ST_IDLE;
         k              <= '0;
         cnt            <= '0;
         flags          <= '0;
         inputs_valid_o <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         error_o        <= 1'b0;
         for (int i = 0; i < N; i++) begin
            north_o[i] <= '0;
            west_o[i]  <= '0;
         end
      end else begin
         inputs_valid_o <= 1'b0;
         done_o         <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state   <= ST_SETUP;
                  k       <= '0;
                  busy_o  <= 1'b1;
                  error_o <= 1'b0;
                  for (int i = 0; i < N; i++) begin
                     north_o[i] <= b_row[i];
                     west_o[i]  <= a_col[i];
                  end
               end
            end
            ST_SETUP: begin
               state          <= ST_PULSE;
               inputs_valid_o <= 1'b1;
            end
            ST_PULSE: begin
               state <= ST_WAIT_DIAG;
               cnt   <= '0;
               flags <= '0;
            end
            ST_WAIT_DIAG: begin
               if (&seen) begin
                  state <= ST_GAP;
                  flags <= '0;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  state   <= ST_DONE;
                  done_o  <= 1'b1;
                  error_o <= 1'b1;
                  flags   <= '0;
                  cnt     <= '0;
               end else begin
                  flags <= seen;
                  cnt   <= cnt + CW'(1);
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (k == K_LAST) begin
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= ST_SETUP;
                     k     <= k + AW'(1);
                     for (int i = 0; i < N; i++) begin
                        north_o[i] <= b_row[i];
                        west_o[i]  <= a_col[i];
                     end
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mesh_feeder.sv
// Directed bench for mesh_feeder (N=3, GAP_CYCLES=5, TIMEOUT_CYCLES=255).
// Cycle numbering inside a sequence: c=0 is the SETUP cycle right after the
// accepted start, so step k pulses at c=1+8k when the mesh answers at once.
module tb_mesh_feeder;

   localparam int N   = 3;
   localparam int DW  = 32;
   localparam int GAP = 5;
   localparam int TMO = 255;

   localparam logic [31:0] F1 = 32'h3F80_0000;
   localparam logic [31:0] F2 = 32'h4000_0000;
   localparam logic [31:0] F3 = 32'h4040_0000;
   localparam logic [31:0] F4 = 32'h4080_0000;
   localparam logic [31:0] F5 = 32'h40A0_0000;
   localparam logic [31:0] F6 = 32'h40C0_0000;
   localparam logic [31:0] F7 = 32'h40E0_0000;
   localparam logic [31:0] F8 = 32'h4100_0000;
   localparam logic [31:0] F9 = 32'h4110_0000;

   typedef logic [31:0] vec_t [N];

   logic          clk = 1'b0;
   logic          rstn;
   logic          a_wr_en;
   logic          b_wr_en;
   logic [1:0]    wr_row;
   logic [1:0]    wr_col;
   logic [DW-1:0] wr_data;
   logic          start;
   logic [DW-1:0] north [N];
   logic [DW-1:0] west [N];
   logic          inputs_valid;
   logic          diag_valid [N];
   logic          busy;
   logic          done;
   logic          error;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] snap_north [N];
   logic [DW-1:0] snap_west [N];

   always #5 clk = ~clk;

   mesh_feeder #(
      .N              (N),
      .DATA_WIDTH     (DW),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .a_wr_en_i      (a_wr_en),
      .b_wr_en_i      (b_wr_en),
      .wr_row_i       (wr_row),
      .wr_col_i       (wr_col),
      .wr_data_i      (wr_data),
      .start_i        (start),
      .north_o        (north),
      .west_o         (west),
      .inputs_valid_o (inputs_valid),
      .diag_valid_i   (diag_valid),
      .busy_o         (busy),
      .done_o         (done),
      .error_o        (error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_diag(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) diag_valid[i] = v[i];
   endtask

   task automatic write_elem(input bit to_a, input bit to_b, input int r, input int c,
                             input logic [31:0] d);
      a_wr_en = to_a;
      b_wr_en = to_b;
      wr_row  = 2'(r);
      wr_col  = 2'(c);
      wr_data = d;
      tick();
      a_wr_en = 1'b0;
      b_wr_en = 1'b0;
   endtask

   task automatic issue_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Plays an ideal mesh (all diagonals one cycle into WAIT_DIAG) from c=1
   // until done_o. At inject_at it raises start_i and an A write to [0][2].
   task automatic run_sequence(input int inject_at, input int snap_at, output int pulses,
                               output int first_p, output int last_p, output int done_at);
      bit respond;
      respond = 1'b0;
      pulses = 0; first_p = -1; last_p = -1; done_at = -1;
      for (int c = 1; c <= 200 && done_at < 0; c++) begin
         tick();
         start   = (c == inject_at);
         a_wr_en = (c == inject_at);
         wr_row  = 2'd0;
         wr_col  = 2'd2;
         wr_data = 32'hFFFF_FFFF;
         set_diag(respond ? {N{1'b1}} : {N{1'b0}});
         respond = 1'b0;
         if (inputs_valid) begin
            pulses++;
            if (first_p < 0) first_p = c;
            last_p  = c;
            respond = 1'b1;
         end
         if (c == snap_at) begin
            for (int j = 0; j < N; j++) begin
               snap_north[j] = north[j];
               snap_west[j]  = west[j];
            end
         end
         if (done) done_at = c;
      end
      start   = 1'b0;
      a_wr_en = 1'b0;
      set_diag('0);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      for (int j = 0; j < N; j++) begin
         checks++;
         if (north[j] !== '0 || west[j] !== '0) begin
            errors++;
            $display("[TB] FAIL reset_operands[%0d]: got north=%h west=%h expected 0", j, north[j], west[j]);
         end
      end
      checks++;
      if ({inputs_valid, busy, done, error} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got valid/busy/done/error=%b expected 0000", {inputs_valid, busy, done, error});
      end
      @(negedge clk);
      rstn = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_identity();
      vec_t exp_w, exp_n;
      int pulses, first_p, last_p, done_at;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            write_elem(1'b1, 1'b0, r, c, 32'(shortreal'(3 * r + c + 1)) == 0 ? 32'h0 :
                       (r == 0 ? (c == 0 ? F1 : c == 1 ? F2 : F3) :
                        r == 1 ? (c == 0 ? F4 : c == 1 ? F5 : F6) :
                                 (c == 0 ? F7 : c == 1 ? F8 : F9)));
            write_elem(1'b0, 1'b1, r, c, (r == c) ? F1 : 32'h0);
         end
      end
      issue_start();
      exp_w = '{F1, F4, F7};
      exp_n = '{F1, 32'h0, 32'h0};
      for (int j = 0; j < N; j++) begin
         checks++;
         if (west[j] !== exp_w[j] || north[j] !== exp_n[j]) begin
            errors++;
            $display("[TB] FAIL identity_step0[%0d]: got west=%h north=%h expected west=%h north=%h",
                     j, west[j], north[j], exp_w[j], exp_n[j]);
         end
      end
      checks++;
      if (busy !== 1'b1 || inputs_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL identity_setup_flags: got busy=%b valid=%b expected busy=1 valid=0", busy, inputs_valid);
      end
      run_sequence(-1, -1, pulses, first_p, last_p, done_at);
      checks++;
      if (pulses !== 3 || first_p !== 1 || last_p !== 17) begin
         errors++;
         $display("[TB] FAIL identity_pulses: got %0d pulses first=%0d last=%0d expected 3 first=1 last=17",
                  pulses, first_p, last_p);
      end
      checks++;
      if (done_at !== 24) begin
         errors++;
         $display("[TB] FAIL identity_done_cycle: got %0d expected 24", done_at);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL identity_back_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_out_of_order();
      int pc [3];
      int exp_pc [3];
      int np, done_at;
      logic [N-1:0] sched;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            write_elem(1'b1, 1'b1, r, c, 32'h1000_0000 + 32'(3 * r + c));
         end
      end
      issue_start();
      for (int j = 0; j < N; j++) begin
         checks++;
         if (north[j] !== 32'h1000_0000 + 32'(j) || west[j] !== 32'h1000_0000 + 32'(3 * j)) begin
            errors++;
            $display("[TB] FAIL ooo_step0[%0d]: got north=%h west=%h expected %h %h", j, north[j], west[j],
                     32'h1000_0000 + 32'(j), 32'h1000_0000 + 32'(3 * j));
         end
      end
      pc = '{-1, -1, -1};
      exp_pc = '{1, 12, 22};
      np = 0;
      done_at = -1;
      for (int c = 1; c <= 40 && done_at < 0; c++) begin
         tick();
         case (c)
            1, 8, 12, 15, 22, 23: sched = 3'b111;
            2:                    sched = 3'b100;
            4:                    sched = 3'b001;
            5:                    sched = 3'b110;
            default:              sched = 3'b000;
         endcase
         set_diag(sched);
         if (inputs_valid) begin
            if (np < 3) pc[np] = c;
            np++;
         end
         if (c == 10) begin
            checks++;
            if (north[0] !== 32'h1000_0000 || west[1] !== 32'h1000_0003) begin
               errors++;
               $display("[TB] FAIL ooo_gap_hold: got north0=%h west1=%h expected 10000000 10000003", north[0], west[1]);
            end
         end
         if (c == 11) begin
            for (int j = 0; j < N; j++) begin
               checks++;
               if (north[j] !== 32'h1000_0003 + 32'(j) || west[j] !== 32'h1000_0001 + 32'(3 * j)) begin
                  errors++;
                  $display("[TB] FAIL ooo_step1[%0d]: got north=%h west=%h expected %h %h", j, north[j], west[j],
                           32'h1000_0003 + 32'(j), 32'h1000_0001 + 32'(3 * j));
               end
            end
         end
         if (done) done_at = c;
      end
      set_diag('0);
      checks++;
      if (np !== 3) begin
         errors++;
         $display("[TB] FAIL ooo_pulse_count: got %0d expected 3", np);
      end
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (pc[s] !== exp_pc[s]) begin
            errors++;
            $display("[TB] FAIL ooo_pulse_cycle[%0d]: got %0d expected %0d", s, pc[s], exp_pc[s]);
         end
      end
      checks++;
      if (done_at !== 29) begin
         errors++;
         $display("[TB] FAIL ooo_done_cycle: got %0d expected 29", done_at);
      end
      tick();
   endtask

   task automatic test_timeout();
      int pulses, first_p, last_p, done_at, p2;
      logic err_at_done;
      issue_start();
      pulses = 0;
      done_at = -1;
      err_at_done = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         tick();
         set_diag(3'b101);
         if (inputs_valid) pulses++;
         if (c == 256) begin
            checks++;
            if (error !== 1'b0) begin
               errors++;
               $display("[TB] FAIL timeout_early_error: got %b expected 0 at wait cycle 255", error);
            end
         end
         if (done && done_at < 0) begin
            done_at = c;
            err_at_done = error;
         end
      end
      set_diag('0);
      checks++;
      if (done_at !== 257 || err_at_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_done: got cycle=%0d error=%b expected cycle=257 error=1", done_at, err_at_done);
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("[TB] FAIL timeout_pulses: got %0d expected 1", pulses);
      end
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_sticky: got error=%b busy=%b expected 1 0", error, busy);
      end
      issue_start();
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_clear_on_start: got %b expected 0", error);
      end
      run_sequence(-1, -1, p2, first_p, last_p, done_at);
      checks++;
      if (p2 !== 3 || done_at !== 24) begin
         errors++;
         $display("[TB] FAIL timeout_rerun: got pulses=%0d done=%0d expected 3 24", p2, done_at);
      end
      tick();
   endtask

   task automatic test_random();
      vec_t ma [N];
      vec_t mb [N];
      vec_t ew, en;
      int pulses, first_p, last_p, done_at;
      ma[0] = '{F3, F2, F1}; ma[1] = '{F6, F5, F4}; ma[2] = '{F9, F8, F7};
      mb[0] = '{F2, F4, F6}; mb[1] = '{F1, F3, F5}; mb[2] = '{F7, F8, F9};
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            write_elem(1'b1, 1'b0, r, c, ma[r][c]);
            write_elem(1'b0, 1'b1, r, c, mb[r][c]);
         end
      end
      issue_start();
      ew = '{F3, F6, F9};
      en = '{F2, F4, F6};
      for (int j = 0; j < N; j++) begin
         checks++;
         if (west[j] !== ew[j] || north[j] !== en[j]) begin
            errors++;
            $display("[TB] FAIL random_step0[%0d]: got west=%h north=%h expected %h %h", j, west[j], north[j], ew[j], en[j]);
         end
      end
      run_sequence(-1, 8, pulses, first_p, last_p, done_at);
      ew = '{F2, F5, F8};
      en = '{F1, F3, F5};
      for (int j = 0; j < N; j++) begin
         checks++;
         if (snap_west[j] !== ew[j] || snap_north[j] !== en[j]) begin
            errors++;
            $display("[TB] FAIL random_step1[%0d]: got west=%h north=%h expected %h %h",
                     j, snap_west[j], snap_north[j], ew[j], en[j]);
         end
      end
      checks++;
      if (pulses !== 3 || done_at !== 24) begin
         errors++;
         $display("[TB] FAIL random_sequence: got pulses=%0d done=%0d expected 3 24", pulses, done_at);
      end
      tick();
   endtask

   task automatic test_ignore_during_step();
      vec_t ew, en;
      int pulses, first_p, last_p, done_at;
      issue_start();
      run_sequence(9, 16, pulses, first_p, last_p, done_at);
      ew = '{F1, F4, F7};
      en = '{F7, F8, F9};
      for (int j = 0; j < N; j++) begin
         checks++;
         if (snap_west[j] !== ew[j] || snap_north[j] !== en[j]) begin
            errors++;
            $display("[TB] FAIL ignore_step2[%0d]: got west=%h north=%h expected %h %h",
                     j, snap_west[j], snap_north[j], ew[j], en[j]);
         end
      end
      checks++;
      if (pulses !== 3 || first_p !== 1 || last_p !== 17 || done_at !== 24) begin
         errors++;
         $display("[TB] FAIL ignore_sequence: got pulses=%0d first=%0d last=%0d done=%0d expected 3 1 17 24",
                  pulses, first_p, last_p, done_at);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ignore_no_restart: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int pulses, first_p, last_p, done_at;
      issue_start();
      tick();
      tick();
      checks++;
      if (north[0] !== F2 || west[0] !== F3 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_pre: got north0=%h west0=%h busy=%b expected %h %h 1", north[0], west[0], busy, F2, F3);
      end
      rstn = 1'b0;
      #1;
      for (int j = 0; j < N; j++) begin
         checks++;
         if (north[j] !== '0 || west[j] !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_operands[%0d]: got north=%h west=%h expected 0", j, north[j], west[j]);
         end
      end
      checks++;
      if ({inputs_valid, busy, done, error} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL midreset_flags: got valid/busy/done/error=%b expected 0000", {inputs_valid, busy, done, error});
      end
      @(negedge clk);
      rstn = 1'b1;
      tick();
      issue_start();
      for (int j = 0; j < N; j++) begin
         checks++;
         if (north[j] !== '0 || west[j] !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_store_cleared[%0d]: got north=%h west=%h expected 0", j, north[j], west[j]);
         end
      end
      run_sequence(-1, -1, pulses, first_p, last_p, done_at);
      checks++;
      if (pulses !== 3 || first_p !== 1 || done_at !== 24) begin
         errors++;
         $display("[TB] FAIL midreset_rerun: got pulses=%0d first=%0d done=%0d expected 3 1 24", pulses, first_p, done_at);
      end
      tick();
   endtask

   initial begin
      rstn    = 1'b0;
      a_wr_en = 1'b0;
      b_wr_en = 1'b0;
      wr_row  = '0;
      wr_col  = '0;
      wr_data = '0;
      start   = 1'b0;
      set_diag('0);
      test_reset();
      test_identity();
      test_out_of_order();
      test_timeout();
      test_random();
      test_ignore_during_step();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached before summary");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
